booth_mult_seq: RTL and testbench

//  Parametrised sequential Booth multiplier; successor to the fixed 8-bit radix-2 datapath.

---
 rtl/booth_mult_seq_if.sv | 32 +++
 rtl/booth_mult_seq.sv | 197 +++++++++++++++++++
 tb/tb_booth_mult_seq.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mult_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult_seq_if
// Description : Operand/result handshake bundle for booth_mult_seq.
//               The master side is the operand producer and result consumer.
//               The slave side is the multiplier itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface booth_mult_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 signed_mode;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, signed_mode, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, signed_mode, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface
`default_nettype wire

// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult_seq
// Description : Parametrised sequential Booth multiplier, signed or unsigned
//               WIDTH-bit operands, 2*WIDTH-bit product, valid/ready on both
//               sides. Radix-2 by default; define BOOTH_RADIX4_EN for
//               modified-Booth radix-4 recoding (WIDTH must then be even).
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    booth_mult_seq_if.slave bus
);

    // Operands carry one extra bit so that the most-negative signed value
    // can be negated and unsigned all-ones values stay positive.
    localparam int c_W1 = WIDTH + 1;

`ifdef BOOTH_RADIX4_EN
    // Radix-4 needs an even-width Q so the digits pair up exactly. The
    // accumulator keeps one guard bit above W1+1 because adding +-2M to a
    // partial sum can exceed the W1+1-bit range before the shift.
    localparam int c_QW    = WIDTH + 2;
    localparam int c_AW    = c_W1 + 2;
    localparam int c_SH    = 2;
    localparam int c_ITERS = WIDTH / 2 + 1;
`else
    localparam int c_QW    = c_W1;
    localparam int c_AW    = c_W1 + 1;
    localparam int c_SH    = 1;
    localparam int c_ITERS = c_W1;
`endif

    localparam int          c_CATW = c_AW + c_QW + 1;
    localparam int          c_CW   = $clog2(c_ITERS + 1);
    localparam [c_CW-1:0]   c_LAST = c_CW'(c_ITERS - 1);

    generate
        if (WIDTH < 2) begin : g_width_min_check
            $error("booth_mult_seq: WIDTH must be at least 2");
        end
`ifdef BOOTH_RADIX4_EN
        if ((WIDTH % 2) != 0) begin : g_width_even_check
            $error("booth_mult_seq: WIDTH must be even for radix-4 recoding");
        end
`endif
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [c_AW-1:0]        r_a;
    logic [c_QW-1:0]        r_q;
    logic                   r_q_m1;
    logic [c_W1-1:0]        r_m;
    logic [c_CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]     r_product;

    logic                   w_in_ready;
    logic                   w_out_valid;
    logic                   w_busy;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_m_sign;
    logic                   w_q_sign;
    logic [c_W1-1:0]        w_m_ext;
    logic [c_QW-1:0]        w_q_ext;
    logic [c_AW-1:0]        w_m_acc;
    logic [c_AW-1:0]        w_sum;
    logic [c_CATW-1:0]      w_cat;
    logic [c_CATW-1:0]      w_sh;

    // The signedness decision is folded into the operand extension at accept
    // time, so later changes on signed_mode cannot disturb a running operation.
    assign w_m_sign = bus.signed_mode & bus.multiplicand[WIDTH-1];
    assign w_q_sign = bus.signed_mode & bus.multiplier[WIDTH-1];
    assign w_m_ext  = {w_m_sign, bus.multiplicand};
    assign w_q_ext  = {{(c_QW - WIDTH){w_q_sign}}, bus.multiplier};
    assign w_m_acc  = {{(c_AW - c_W1){r_m[c_W1-1]}}, r_m};

    assign w_accept = bus.in_valid & w_in_ready;
    assign w_last   = (r_state == S_BUSY) && (r_cnt == c_LAST);

    // Booth recoding of the low Q bits selects what is added to the accumulator.
`ifdef BOOTH_RADIX4_EN
    logic [c_AW-1:0] w_m_x2;
    assign w_m_x2 = {w_m_acc[c_AW-2:0], 1'b0};

    always_comb begin
        w_sum = r_a;
        case ({r_q[1:0], r_q_m1})
            3'b001, 3'b010: w_sum = r_a + w_m_acc;
            3'b011:         w_sum = r_a + w_m_x2;
            3'b100:         w_sum = r_a - w_m_x2;
            3'b101, 3'b110: w_sum = r_a - w_m_acc;
            default:        w_sum = r_a;
        endcase
    end
`else
    always_comb begin
        w_sum = r_a;
        case ({r_q[0], r_q_m1})
            2'b01:   w_sum = r_a + w_m_acc;
            2'b10:   w_sum = r_a - w_m_acc;
            default: w_sum = r_a;
        endcase
    end
`endif

    // Arithmetic right shift of the whole {A,Q,Q_-1} chain.
    assign w_cat = {w_sum, r_q, r_q_m1};
    assign w_sh  = {{c_SH{w_cat[c_CATW-1]}}, w_cat[c_CATW-1:c_SH]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, one Booth iteration per BUSY cycle, product capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_q       <= '0;
            r_q_m1    <= 1'b0;
            r_m       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a       <= '0;
            r_q       <= w_q_ext;
            r_q_m1    <= 1'b0;
            r_m       <= w_m_ext;
            r_cnt     <= '0;
        end else if (r_state == S_BUSY) begin
            r_a    <= w_sh[c_CATW-1:c_QW+1];
            r_q    <= w_sh[c_QW:1];
            r_q_m1 <= w_sh[0];
            if (w_last) begin
                // Low 2*WIDTH bits of {A,Q} after the final shift.
                r_product <= w_sh[2*WIDTH:1];
            end else begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.product   = r_product;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mult_seq
// Description : Self-checking bench for booth_mult_seq: cycle-level
//               behavioural model of the handshake plus an arithmetic
//               product reference, randomized and directed operations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mult_seq;

    localparam int WIDTH = 8;
`ifdef BOOTH_RADIX4_EN
    localparam int LAT     = WIDTH / 2 + 1;
    localparam int LAT_LIT = 5;
`else
    localparam int LAT     = WIDTH + 1;
    localparam int LAT_LIT = 9;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    booth_mult_seq_if #(.WIDTH(WIDTH)) bus ();

    booth_mult_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Arithmetic reference: plain integer multiply of the interpreted operands.
    function automatic logic [2*WIDTH-1:0] ref_prod(input logic s,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        longint sa;
        longint sb;
        longint p;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        p  = sa * sb;
        return p[2*WIDTH-1:0];
    endfunction

    // Observable-behaviour model: an accepted operation yields its product
    // LAT edges later and holds it until the consumer takes it.
    logic               m_in_ready;
    logic               m_out_valid;
    logic               m_busy;
    logic [2*WIDTH-1:0] m_product;
    logic [2*WIDTH-1:0] m_pending;
    int                 m_remain;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_in_ready  <= 1'b1;
            m_out_valid <= 1'b0;
            m_busy      <= 1'b0;
            m_product   <= '0;
            m_pending   <= '0;
            m_remain    <= 0;
        end else if (m_in_ready) begin
            if (bus.in_valid) begin
                m_pending  <= ref_prod(bus.signed_mode, bus.multiplicand, bus.multiplier);
                m_remain   <= LAT;
                m_in_ready <= 1'b0;
                m_busy     <= 1'b1;
            end
        end else if (m_busy) begin
            m_remain <= m_remain - 1;
            if (m_remain == 1) begin
                m_busy      <= 1'b0;
                m_out_valid <= 1'b1;
                m_product   <= m_pending;
            end
        end else if (m_out_valid && bus.out_ready) begin
            m_out_valid <= 1'b0;
            m_in_ready  <= 1'b1;
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("in_ready",  64'(bus.in_ready),  64'(m_in_ready));
            check("out_valid", 64'(bus.out_valid), 64'(m_out_valid));
            check("busy",      64'(bus.busy),      64'(m_busy));
            if (m_out_valid || rst) begin
                check("product", 64'(bus.product), 64'(m_product));
            end
        end
    end

    // Present operands and hold them until the edge that accepts them.
    task automatic send(input logic s, input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
        int t;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) bound_fail("accept_wait");
        bus.in_valid     = 1'b1;
        bus.signed_mode  = s;
        bus.multiplicand = m;
        bus.multiplier   = q;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Wait for the result while throwing junk at the input side, then
    // consume it after an optional stall. lat counts edges since accept.
    task automatic collect(input int stall, input bit early_ready,
                           output int lat, output logic [2*WIDTH-1:0] prod);
        int t;
        t = 0;
        bus.out_ready = early_ready;
        while (bus.out_valid !== 1'b1 && t < 100) begin
            bus.in_valid     = 1'($urandom_range(0, 1));
            bus.signed_mode  = 1'($urandom);
            bus.multiplicand = WIDTH'($urandom);
            bus.multiplier   = WIDTH'($urandom);
            @(negedge clk);
            t++;
        end
        bus.in_valid = 1'b0;
        lat  = t;
        prod = bus.product;
        if (t >= 100) bound_fail("result_wait");
        if (!early_ready) begin
            repeat (stall) @(negedge clk);
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] pick_operand();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = {1'b1, {(WIDTH-1){1'b0}}};
            1:       v = '1;
            2:       v = {1'b0, {(WIDTH-1){1'b1}}};
            3:       v = '0;
            default: v = WIDTH'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        int                 lat;
        logic [2*WIDTH-1:0] prod;

        bus.in_valid     = 1'b0;
        bus.signed_mode  = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        bus.out_ready    = 1'b0;

        // Pin the reference model to hand-computed products.
        check("model_pin_neg128sq", 64'(ref_prod(1'b1, 8'h80, 8'h80)), 64'h4000);
        check("model_pin_255sq",    64'(ref_prod(1'b0, 8'hFF, 8'hFF)), 64'hFE01);
        check("model_pin_m7x3",     64'(ref_prod(1'b1, 8'hF9, 8'h03)), 64'hFFEB);

        repeat (3) @(negedge clk);
        check("reset_in_ready",  64'(bus.in_ready),  64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_product",   64'(bus.product),   64'd0);
        #2 rst = 1'b0;
        @(negedge clk);

        // Directed: signed most-negative squared, with latency.
        send(1'b1, 8'h80, 8'h80);
        collect(2, 1'b0, lat, prod);
        check("lat_neg128sq",  64'(lat),  64'(LAT_LIT));
        check("prod_neg128sq", 64'(prod), 64'h4000);

        // Directed: unsigned all-ones with 5-cycle backpressure.
        send(1'b0, 8'hFF, 8'hFF);
        collect(5, 1'b0, lat, prod);
        check("prod_255sq", 64'(prod), 64'hFE01);
        check("ready_after_pulse", 64'(bus.in_ready), 64'd1);

        // Directed: same bit patterns, signed then unsigned.
        send(1'b1, 8'hF9, 8'h03);
        collect(0, 1'b1, lat, prod);
        check("prod_m7x3_s", 64'(prod), 64'hFFEB);
        send(1'b0, 8'hF9, 8'h03);
        collect(1, 1'b0, lat, prod);
        check("prod_249x3_u", 64'(prod), 64'h02EB);

`ifdef BOOTH_RADIX4_EN
        send(1'b1, 8'h80, 8'h7F);
        collect(0, 1'b0, lat, prod);
        check("lat_r4",  64'(lat),  64'd5);
        check("prod_r4", 64'(prod), 64'hC080);
`endif

        // Reset in the middle of an operation aborts it.
        send(1'b1, 8'd55, 8'd77);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_in_ready",  64'(bus.in_ready),  64'd1);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_product",   64'(bus.product),   64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        send(1'b0, 8'd0, 8'd123);
        collect(0, 1'b0, lat, prod);
        check("prod_after_abort", 64'(prod), 64'd0);

        // Randomized operations with random stalls and idle gaps.
        for (int i = 0; i < 250; i++) begin
            send(1'($urandom), pick_operand(), pick_operand());
            collect($urandom_range(0, 3), ($urandom_range(0, 3) == 0), lat, prod);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
